// File: rtl/clock_lock_sequencer_if.sv
// Requester and CLOCK-side bundle for clock_lock_sequencer.
// slave = sequencer side, master = requesters plus the CLOCK instance.
interface clock_lock_sequencer_if #(
    parameter int N_REQ = 4,
    parameter int TW    = 16
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*TW-1:0] tgt;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    fail;
    logic                busy;
    logic                osc_resn;
    logic [TW-1:0]       osc_target;
    logic                osc_lock;

    modport slave (
        input  req, tgt, osc_lock,
        output gnt, fail, busy, osc_resn, osc_target
    );

    modport master (
        output req, tgt, osc_lock,
        input  gnt, fail, busy, osc_resn, osc_target
    );
endinterface

// File: rtl/clock_lock_sequencer.sv
// Shares one CLOCK (oscillator + lock loop) among N_REQ requesters.
// Optional macro CLKSEQ_RETRY_EN: retry the lock MAX_RETRY extra times.
module clock_lock_sequencer #(
    parameter int N_REQ      = 4,
    parameter int TW         = 16,
    parameter int RESET_HOLD = 4,
    parameter int TIMEOUT    = 4096,
    parameter int MAX_RETRY  = 3
) (
    input logic                 clk,
    input logic                 res,
    clock_lock_sequencer_if.slave bus
);
    localparam int OW   = $clog2(N_REQ);
    localparam int CMAX = (TIMEOUT > RESET_HOLD) ? TIMEOUT : RESET_HOLD;
    localparam int CW   = $clog2(CMAX);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    if (N_REQ < 2 || N_REQ > 8 || RESET_HOLD < 1 ||
        TIMEOUT < 4 || MAX_RETRY < 0) begin : g_bad_params
        $error("clock_lock_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE, S_HOLD, S_WAIT, S_GRANT
    } state_t;

    state_t            state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     rr_q, rr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]  mask_q, mask_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  fail_q, fail_d;
    logic              busy_q, busy_d;
    logic              osc_resn_q, osc_resn_d;
    logic [TW-1:0]     osc_target_q, osc_target_d;
    logic              sync1_q, lock_s_q;

    logic [N_REQ-1:0]  eligible;
    logic              pick_vld;
    logic [OW-1:0]     pick_idx;
    logic [OW-1:0]     scan_idx;
    logic [TW-1:0]     pick_tgt;
    logic              owner_req;
    logic              retry_left;

`ifdef CLKSEQ_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 1) + 1;
    logic [RW-1:0] retry_q, retry_d;
    assign retry_left = (retry_q < RW'(MAX_RETRY));
`else
    assign retry_left = 1'b0;
`endif

    assign eligible  = bus.req & ~mask_q;
    assign owner_req = bus.req[owner_q];

    // Round-robin pick: first eligible index at or after rr_q.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        pick_tgt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = OW'((int'(rr_q) + i) % N_REQ);
            if (!pick_vld && eligible[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (OW'(i) == pick_idx) begin
                pick_tgt = bus.tgt[i*TW +: TW];
            end
        end
    end

    // Next state and registered outputs; an owner drop beats lock/timeout.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        mask_d       = mask_q & bus.req;
        gnt_d        = gnt_q;
        fail_d       = '0;
        osc_resn_d   = osc_resn_q;
        osc_target_d = osc_target_q;
`ifdef CLKSEQ_RETRY_EN
        retry_d      = retry_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                gnt_d      = '0;
                osc_resn_d = 1'b0;
                if (pick_vld) begin
                    owner_d      = pick_idx;
                    rr_d         = (pick_idx == OW'(N_REQ - 1)) ?
                                   '0 : pick_idx + 1'b1;
                    osc_target_d = pick_tgt;
                    cnt_d        = '0;
`ifdef CLKSEQ_RETRY_EN
                    retry_d      = '0;
`endif
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!owner_req) begin
                    osc_resn_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (cnt_q == HOLD_LAST) begin
                    cnt_d      = '0;
                    osc_resn_d = 1'b1;
                    state_d    = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (!owner_req) begin
                    osc_resn_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (lock_s_q) begin
                    gnt_d          = '0;
                    gnt_d[owner_q] = 1'b1;
                    state_d        = S_GRANT;
                end else if (cnt_q == WAIT_LAST) begin
                    osc_resn_d = 1'b0;
                    cnt_d      = '0;
                    if (retry_left) begin
`ifdef CLKSEQ_RETRY_EN
                        retry_d = retry_q + 1'b1;
`endif
                        state_d = S_HOLD;
                    end else begin
                        fail_d[owner_q] = 1'b1;
                        mask_d[owner_q] = 1'b1;
                        state_d         = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GRANT: begin
                if (!owner_req) begin
                    gnt_d      = '0;
                    osc_resn_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, output and lock-synchroniser registers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            rr_q         <= '0;
            cnt_q        <= '0;
            mask_q       <= '0;
            gnt_q        <= '0;
            fail_q       <= '0;
            busy_q       <= 1'b0;
            osc_resn_q   <= 1'b0;
            osc_target_q <= '0;
            sync1_q      <= 1'b0;
            lock_s_q     <= 1'b0;
`ifdef CLKSEQ_RETRY_EN
            retry_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            gnt_q        <= gnt_d;
            fail_q       <= fail_d;
            busy_q       <= busy_d;
            osc_resn_q   <= osc_resn_d;
            osc_target_q <= osc_target_d;
            sync1_q      <= bus.osc_lock;
            lock_s_q     <= sync1_q;
`ifdef CLKSEQ_RETRY_EN
            retry_q      <= retry_d;
`endif
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.fail       = fail_q;
    assign bus.busy       = busy_q;
    assign bus.osc_resn   = osc_resn_q;
    assign bus.osc_target = osc_target_q;
endmodule

// File: tb/tb_clock_lock_sequencer.sv
// Directed bench for clock_lock_sequencer with a grant/fail scoreboard.
// Includes a behavioural CLOCK lock model driven from osc_resn.
module tb_clock_lock_sequencer;
    localparam int N  = 4;
    localparam int TW = 16;
    localparam int RH = 4;
    localparam int TO = 4096;
`ifdef CLKSEQ_RETRY_EN
    localparam int ATT = 4;
`else
    localparam int ATT = 1;
`endif

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    clock_lock_sequencer_if #(.N_REQ(N), .TW(TW)) bus ();

    clock_lock_sequencer #(
        .N_REQ(N), .TW(TW), .RESET_HOLD(RH),
        .TIMEOUT(TO), .MAX_RETRY(3)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus.slave)
    );

    int n_run  = 0;
    int n_fail = 0;
    int exp_q[$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int oh_idx(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic pop_cmp(int ev);
        if (exp_q.size() == 0) check("unexpected_event", ev, 32'hffff_ffff);
        else check("event_order", ev, exp_q.pop_front());
    endtask

    // CLOCK model: locks lock_dly cycles after resn rises (optionally
    // only on attempt lock_att); lock is cleared while resn is low.
    int   lock_dly = 50;
    int   lock_att = -1;
    int   att = 0;
    int   lk_cnt = 0;
    logic resn_prev = 1'b0;
    always @(posedge clk) begin
        resn_prev <= bus.osc_resn;
        if (bus.osc_resn && !resn_prev) att <= att + 1;
        if (!bus.osc_resn) begin
            lk_cnt       <= 0;
            bus.osc_lock <= 1'b0;
        end else if (lk_cnt < lock_dly) begin
            lk_cnt <= lk_cnt + 1;
        end else if (lock_att == -1 || att == lock_att) begin
            bus.osc_lock <= 1'b1;
        end
    end

    // Scoreboard monitor: grant rises and fail pulses in expected order.
    logic [N-1:0] gnt_prev = '0;
    always @(negedge clk) begin
        if (!res) begin
            if ((bus.gnt | bus.fail) != '0)
                check("excl", {31'b0, $onehot0(bus.gnt) && $onehot0(bus.fail)
                      && !(bus.gnt != '0 && bus.fail != '0)}, 1);
            if (bus.gnt != '0 && gnt_prev == '0) pop_cmp(oh_idx(bus.gnt));
            if (bus.fail != '0) pop_cmp(100 + oh_idx(bus.fail));
        end
        gnt_prev <= bus.gnt;
    end

    task automatic wait_gnt(int idx, int budget);
        int c = 0;
        while (bus.gnt[idx] !== 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("wait_gnt", bus.gnt, 32'(1 << idx));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, low, rises, last;
        logic prev;
        res     = 1'b1;
        bus.req = '0;
        bus.tgt = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", bus.gnt, 0);
        check("rst_fail", bus.fail, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_resn", bus.osc_resn, 0);
        check("rst_target", bus.osc_target, 0);
        res = 1'b0;
        @(negedge clk);

        // 1: single requester, lock after 50 cycles
        bus.tgt[1*TW +: TW] = 16'h0100;
        bus.req = 4'b0010;
        exp_q.push_back(1);
        @(negedge clk);
        check("t1_busy", bus.busy, 1);
        check("t1_target", bus.osc_target, 16'h0100);
        check("t1_resn_low", bus.osc_resn, 0);
        low = 1;
        while (!bus.osc_resn && low < 100) begin
            @(negedge clk);
            if (!bus.osc_resn) low++;
        end
        check("t1_hold_len", low, RH);
        bus.tgt[1*TW +: TW] = 16'h0200;
        c = 0;
        while (!bus.osc_lock && c < 200) begin @(negedge clk); c++; end
        c = 0;
        while (!bus.gnt[1] && c < 10) begin @(negedge clk); c++; end
        check("t1_lock_to_gnt", c, 3);
        check("t1_gnt", bus.gnt, 4'b0010);
        check("t1_target_kept", bus.osc_target, 16'h0100);
        repeat (3) @(negedge clk);
        check("t1_gnt_held", bus.gnt, 4'b0010);
        check("t1_resn_high", bus.osc_resn, 1);
        bus.req = '0;
        @(negedge clk);
        check("t1_rel_gnt", bus.gnt, 0);
        check("t1_rel_resn", bus.osc_resn, 0);
        check("t1_rel_busy", bus.busy, 0);
        repeat (2) @(negedge clk);

        // 2: all four request from reset, served in order 0..3
        res = 1'b1;
        @(negedge clk);
        bus.tgt  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        bus.req  = 4'b1111;
        lock_dly = 5;
        for (int k = 0; k < N; k++) exp_q.push_back(k);
        res = 1'b0;
        for (int k = 0; k < N; k++) begin
            wait_gnt(k, 200);
            check("t2_target", bus.osc_target, 32'(16'h1111 * (k + 1)));
            bus.req[k] = 1'b0;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // 3/4: lock never rises -> fail pulse after all attempts
        lock_att = -2;
        bus.req  = 4'b0100;
        exp_q.push_back(102);
        rises = 0; last = 0; c = 0; prev = 1'b0;
        while (!bus.fail[2] && c < ATT * (TO + RH + 20)) begin
            @(negedge clk);
            c++;
            if (bus.osc_resn && !prev) begin rises++; last = c; end
            prev = bus.osc_resn;
        end
        check("t3_attempts", rises, ATT);
        check("t3_wait_len", c - last, TO);
        check("t3_fail", bus.fail, 4'b0100);
        check("t3_resn", bus.osc_resn, 0);
        @(negedge clk);
        check("t3_fail_pulse", bus.fail, 0);
        repeat (10) @(negedge clk);
        check("t3_masked_busy", bus.busy, 0);
        bus.req = '0;
        @(negedge clk);
        bus.req = 4'b0100;
        @(negedge clk);
        check("t3_unmasked_busy", bus.busy, 1);
        bus.req = '0;
        @(negedge clk);
        check("t3_abort_busy", bus.busy, 0);
`ifdef CLKSEQ_RETRY_EN
        lock_att = att + 3;
        lock_dly = 20;
        bus.req  = 4'b0100;
        exp_q.push_back(2);
        rises = 0; c = 0; prev = 1'b0;
        while (!bus.gnt[2] && c < ATT * (TO + RH + 20)) begin
            @(negedge clk);
            c++;
            if (bus.osc_resn && !prev) rises++;
            prev = bus.osc_resn;
        end
        check("t4_attempts", rises, 3);
        check("t4_gnt", bus.gnt, 4'b0100);
        bus.req = '0;
        @(negedge clk);
`endif

        // 5: owner drops during WAIT, pending requester 3 served next
        lock_att = -1;
        lock_dly = 50;
        repeat (2) @(negedge clk);
        bus.req = 4'b0001;
        c = 0;
        while (!bus.osc_resn && c < 20) begin @(negedge clk); c++; end
        check("t5_in_wait", bus.osc_resn, 1);
        bus.req = 4'b1001;
        exp_q.push_back(3);
        repeat (5) @(negedge clk);
        check("t5_undisturbed", bus.osc_target, 16'h1111);
        bus.req = 4'b1000;
        @(negedge clk);
        check("t5_abort_busy", bus.busy, 0);
        check("t5_abort_resn", bus.osc_resn, 0);
        check("t5_abort_gf", {bus.gnt, bus.fail}, 0);
        @(negedge clk);
        check("t5_next_target", bus.osc_target, 16'h4444);
        wait_gnt(3, 200);
        bus.req = '0;
        @(negedge clk);

        // 6: async reset during GRANT, re-arbitration from index 0
        bus.req = 4'b0010;
        exp_q.push_back(1);
        wait_gnt(1, 200);
        bus.req = 4'b1010;
        repeat (3) @(negedge clk);
        check("t6_gnt_held", bus.gnt, 4'b0010);
        #2 res = 1'b1;
        #1;
        check("t6_rst_gnt", bus.gnt, 0);
        check("t6_rst_resn", bus.osc_resn, 0);
        check("t6_rst_busy", bus.busy, 0);
        @(negedge clk);
        res = 1'b0;
        exp_q.push_back(1);
        exp_q.push_back(3);
        wait_gnt(1, 200);
        bus.req = 4'b1000;
        @(negedge clk);
        wait_gnt(3, 200);
        bus.req = '0;
        repeat (5) @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
